// File: rtl/dmem_responder_if.sv
// dmem_responder_if: request/response bus between the MEM-stage requester and the data-memory responder
interface dmem_responder_if #(parameter int ADDR_W = 12);
  logic              REQ_VALID;
  logic              REQ_READY;
  logic [ADDR_W-1:0] D_MEM_ADDR;
  logic              D_MEM_WEN;
  logic [3:0]        D_MEM_BE;
  logic              is_sign;
  logic [31:0]       D_MEM_DI;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [31:0]       D_MEM_DOUT;
  logic              MISALIGN;
  modport master (
    output REQ_VALID, D_MEM_ADDR, D_MEM_WEN, D_MEM_BE, is_sign, D_MEM_DI, RSP_READY,
    input  REQ_READY, RSP_VALID, D_MEM_DOUT, MISALIGN
  );
  modport slave (
    input  REQ_VALID, D_MEM_ADDR, D_MEM_WEN, D_MEM_BE, is_sign, D_MEM_DI, RSP_READY,
    output REQ_READY, RSP_VALID, D_MEM_DOUT, MISALIGN
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency data-memory target with lane alignment and load extension; DMEM_ERR_RESP_EN turns misaligned accesses into error responses
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input logic             CLK,
  input logic             RSTn,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 1 << (ADDR_W - 2);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t            state;
  logic [3:0]        cnt;
  logic              req_ready, rsp_valid, misalign;
  logic [31:0]       dout;
  logic [ADDR_W-1:0] addr_q;
  logic              wen_q, sign_q;
  logic [3:0]        be_q;
  logic [31:0]       di_q;
  logic [31:0]       mem [0:DEPTH-1];
  logic [ADDR_W-3:0] idx;
  logic [1:0]        off, off_a;
  logic              is_b, is_h, ok, mis_out, fire;
  logic [3:0]        be_a, lanes;
  logic [31:0]       wdata, raw, ld;
  assign idx   = addr_q[ADDR_W-1:2];
  assign off   = addr_q[1:0];
  assign is_b  = be_q == 4'b0001;
  assign is_h  = be_q == 4'b0011;
  // Sizes snap to their natural alignment; unknown BE codes behave as word
  assign off_a = is_b ? off : is_h ? {off[1], 1'b0} : 2'b00;
  assign be_a  = is_b ? 4'b0001 : is_h ? 4'b0011 : 4'b1111;
  assign lanes = be_a << off_a;
  assign wdata = di_q << {off_a, 3'b000};
  assign raw   = mem[idx] >> {off_a, 3'b000};
  assign ld    = is_b ? {{24{sign_q & raw[7]}}, raw[7:0]}
               : is_h ? {{16{sign_q & raw[15]}}, raw[15:0]} : raw;
`ifdef DMEM_ERR_RESP_EN
  logic is_w, mis;
  assign is_w    = be_q == 4'b1111;
  assign mis     = (is_h & off[0]) | (is_w & |off) | !(is_b | is_h | is_w);
  assign ok      = !mis;
  assign mis_out = mis;
`else
  assign ok      = 1'b1;
  assign mis_out = 1'b0;
`endif
  assign fire = state == WAIT && cnt == 4'd0;
  always_ff @(posedge CLK)
    if (RSTn && fire && !wen_q && ok)
      for (int i = 0; i < 4; i++)
        if (lanes[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      dout      <= 32'd0;
      misalign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (bus.REQ_VALID && req_ready) begin
            addr_q    <= bus.D_MEM_ADDR;
            wen_q     <= bus.D_MEM_WEN;
            be_q      <= bus.D_MEM_BE;
            sign_q    <= bus.is_sign;
            di_q      <= bus.D_MEM_DI;
            cnt       <= 4'(LATENCY - 1);
            req_ready <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            dout      <= (wen_q && ok) ? ld : 32'd0;
            misalign  <= mis_out;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (bus.RSP_READY) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.REQ_READY  = req_ready;
  assign bus.RSP_VALID  = rsp_valid;
  assign bus.D_MEM_DOUT = dout;
  assign bus.MISALIGN   = misalign;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vectors for dmem_responder (LATENCY=2), both DMEM_ERR_RESP_EN builds
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  dmem_responder_if #(.ADDR_W(12)) bus();
  dmem_responder #(.ADDR_W(12), .LATENCY(2)) dut (.CLK(clk), .RSTn(rstn), .bus(bus));
  int n_vec = 0;
  int n_err = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [11:0] a, input logic w, input logic [3:0] be, input logic s, input logic [31:0] di);
    bus.REQ_VALID  = 1'b1;
    bus.D_MEM_ADDR = a;
    bus.D_MEM_WEN  = w;
    bus.D_MEM_BE   = be;
    bus.is_sign    = s;
    bus.D_MEM_DI   = di;
  endtask
  task automatic op(input string tag, input logic [11:0] a, input logic w, input logic [3:0] be,
                    input logic s, input logic [31:0] di, input logic [31:0] exp_d, input logic exp_m);
    int n = 0;
    int lat = 0;
    while (!bus.REQ_READY && n < 20) begin step(); n++; end
    check({tag, " ready"}, 32'(bus.REQ_READY), 32'd1);
    drive(a, w, be, s, di);
    step();
    bus.REQ_VALID  = 1'b0;
    bus.D_MEM_ADDR = 12'($urandom);
    bus.D_MEM_WEN  = ~w;
    bus.D_MEM_BE   = 4'($urandom);
    bus.D_MEM_DI   = $urandom;
    while (!bus.RSP_VALID && lat < 20) begin step(); lat++; end
    check({tag, " lat"}, 32'(lat), 32'd2);
    check({tag, " dout"}, bus.D_MEM_DOUT, exp_d);
    check({tag, " mis"}, 32'(bus.MISALIGN), 32'(exp_m));
    bus.RSP_READY = 1'b1;
    step();
    bus.RSP_READY = 1'b0;
    check({tag, " idle"}, {30'd0, bus.RSP_VALID, bus.REQ_READY}, 32'd1);
  endtask
  initial begin
    int w;
    bus.REQ_VALID = 1'b0; bus.RSP_READY = 1'b0; bus.D_MEM_ADDR = '0; bus.D_MEM_WEN = 1'b1;
    bus.D_MEM_BE = 4'b1111; bus.is_sign = 1'b0; bus.D_MEM_DI = '0;
    repeat (3) step();
    check("rst ready", 32'(bus.REQ_READY), 32'd0);
    check("rst rvalid", 32'(bus.RSP_VALID), 32'd0);
    check("rst dout", bus.D_MEM_DOUT, 32'd0);
    check("rst mis", 32'(bus.MISALIGN), 32'd0);
    rstn = 1'b1;
    check("rel ready0", 32'(bus.REQ_READY), 32'd0);
    step();
    check("rel ready1", 32'(bus.REQ_READY), 32'd1);
    op("st w010", 12'h010, 1'b0, 4'b1111, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
    op("ld w010", 12'h010, 1'b1, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    op("st b013", 12'h013, 1'b0, 4'b0001, 1'b0, 32'h00000080, 32'h0, 1'b0);
    op("ld bs013", 12'h013, 1'b1, 4'b0001, 1'b1, 32'h0, 32'hFFFFFF80, 1'b0);
    op("ld bu013", 12'h013, 1'b1, 4'b0001, 1'b0, 32'h0, 32'h00000080, 1'b0);
    op("ld w010b", 12'h010, 1'b1, 4'b1111, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
    op("ld bs011", 12'h011, 1'b1, 4'b0001, 1'b1, 32'h0, 32'hFFFFFFBE, 1'b0);
    op("st w020", 12'h020, 1'b0, 4'b1111, 1'b0, 32'h12345678, 32'h0, 1'b0);
    op("st h022", 12'h022, 1'b0, 4'b0011, 1'b0, 32'h00008001, 32'h0, 1'b0);
    op("ld hs022", 12'h022, 1'b1, 4'b0011, 1'b1, 32'h0, 32'hFFFF8001, 1'b0);
    op("ld hs020", 12'h020, 1'b1, 4'b0011, 1'b1, 32'h0, 32'h00005678, 1'b0);
    op("ld w020", 12'h020, 1'b1, 4'b1111, 1'b0, 32'h0, 32'h80015678, 1'b0);
    // Response held for five cycles while a competing store is offered
    drive(12'h010, 1'b1, 4'b1111, 1'b0, 32'h0);
    step();
    drive(12'h010, 1'b0, 4'b1111, 1'b0, 32'h0);
    w = 0;
    while (!bus.RSP_VALID && w < 20) begin step(); w++; end
    for (int i = 0; i < 5; i++) begin
      check("hold rvalid", 32'(bus.RSP_VALID), 32'd1);
      check("hold dout", bus.D_MEM_DOUT, 32'h80ADBEEF);
      check("hold ready", 32'(bus.REQ_READY), 32'd0);
      step();
    end
    bus.REQ_VALID = 1'b0;
    bus.RSP_READY = 1'b1;
    step();
    bus.RSP_READY = 1'b0;
    check("hold rel", {30'd0, bus.RSP_VALID, bus.REQ_READY}, 32'd1);
    op("ld w010c", 12'h010, 1'b1, 4'b1111, 1'b0, 32'h0, 32'h80ADBEEF, 1'b0);
    // Reset while a store is still counting down
    op("st w040", 12'h040, 1'b0, 4'b1111, 1'b0, 32'h11111111, 32'h0, 1'b0);
    drive(12'h040, 1'b0, 4'b1111, 1'b0, 32'hCAFEF00D);
    step();
    bus.REQ_VALID = 1'b0;
    rstn = 1'b0;
    step();
    step();
    check("mid rst rvalid", 32'(bus.RSP_VALID), 32'd0);
    rstn = 1'b1;
    step();
    step();
    check("post rst", {30'd0, bus.RSP_VALID, bus.REQ_READY}, 32'd1);
    op("ld w040", 12'h040, 1'b1, 4'b1111, 1'b0, 32'h0, 32'h11111111, 1'b0);
    op("st w030", 12'h030, 1'b0, 4'b1111, 1'b0, 32'h0A0B0C0D, 32'h0, 1'b0);
`ifdef DMEM_ERR_RESP_EN
    op("st w031", 12'h031, 1'b0, 4'b1111, 1'b0, 32'hAABBCCDD, 32'h0, 1'b1);
    op("ld w030", 12'h030, 1'b1, 4'b1111, 1'b0, 32'h0, 32'h0A0B0C0D, 1'b0);
    op("ld h023", 12'h023, 1'b1, 4'b0011, 1'b0, 32'h0, 32'h0, 1'b1);
    op("ld be4", 12'h020, 1'b1, 4'b0100, 1'b0, 32'h0, 32'h0, 1'b1);
`else
    op("st w031", 12'h031, 1'b0, 4'b1111, 1'b0, 32'hAABBCCDD, 32'h0, 1'b0);
    op("ld w030", 12'h030, 1'b1, 4'b1111, 1'b0, 32'h0, 32'hAABBCCDD, 1'b0);
    op("ld h023", 12'h023, 1'b1, 4'b0011, 1'b0, 32'h0, 32'h00008001, 1'b0);
    op("ld be4", 12'h021, 1'b1, 4'b0100, 1'b0, 32'h0, 32'h80015678, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the data-memory interface driven by the multicycle control unit (D_MEM_WEN, D_MEM_BE, is_sign).
- Accepts one load/store request at a time over a valid/ready handshake and holds word storage internally.
- Performs byte-lane alignment, then sign/zero extension on loads.
- Returns a response after a fixed programmable latency, emulating a slow memory so the MEM stage is exercised with stalls.

Parameters:
- ADDR_W, 12: byte-address width; storage depth is 2^(ADDR_W-2) 32-bit words.
- LATENCY, 2: cycles from request accept to RSP_VALID; legal range 1..15.

Ports:
- CLK  in  1  clock, rising edge.
- RSTn  in  1  synchronous, active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  responder can accept a request.
- D_MEM_ADDR  in  ADDR_W  byte address.
- D_MEM_WEN  in  1  0 = store, 1 = load (active-low write enable).
- D_MEM_BE  in  4  access size: 0001 byte, 0011 half, 1111 word.
- is_sign  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
- D_MEM_DI  in  32  store data, right-aligned.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  requester consumes the response.
- D_MEM_DOUT  out  32  load result, extended; 0 for stores.
- MISALIGN  out  1  error flag qualified by RSP_VALID.

Behaviour:
- Reset is synchronous on RSTn=0. It sets state IDLE and clears REQ_READY, RSP_VALID, D_MEM_DOUT, MISALIGN and the latency counter. Storage contents are not reset.
- REQ_READY is registered. It is 1 only in IDLE, so it first reads 1 in the cycle after RSTn deasserts.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on REQ_VALID & REQ_READY, latch addr, WEN, BE, is_sign and DI; load cnt = LATENCY-1; go to WAIT. REQ_READY drops on the next cycle.
- WAIT: if cnt != 0, decrement. If cnt == 0, perform the access and go to RESP.
- Access timing: a store commits to storage, and a load samples storage, at the edge entering RESP. RSP_VALID therefore rises exactly LATENCY cycles after the accept edge.
- RESP: RSP_VALID=1, with D_MEM_DOUT and MISALIGN stable.
  - On RSP_READY=1, return to IDLE; RSP_VALID=0 and REQ_READY=1 on the next cycle.
  - Minimum back-to-back period is LATENCY+2 cycles.
- REQ_VALID is ignored outside IDLE. Requester inputs may change freely after accept because they are latched.
- Word index = addr[ADDR_W-1:2]; byte offset off = addr[1:0].
- Store: lane mask = BE << off, lane data = DI << (8*off). Only masked bytes are updated.
- Load: raw = word >> (8*off), then masked to 8/16/32 bits per BE. If is_sign=1, bit 7 or 15 is replicated; otherwise upper bits are 0.
- Misaligned access is any of: half with off[0]=1, word with off != 0, or a BE not in {0001, 0011, 1111}.
- Reset mid-operation (WAIT or RESP) returns to IDLE with no response. A store that has not yet entered RESP never commits.
- A store followed by a load to the same word returns the new data; there is no hazard window, because storage is updated before RESP.

Optional Feature:
- Macro: DMEM_ERR_RESP_EN.
- Defined: a misaligned request performs no write and no read; its response has D_MEM_DOUT=0 and MISALIGN=1, with normal latency.
- Undefined: MISALIGN is tied 0, and misaligned accesses are forced to alignment by clearing off bits per size (half clears off[0], word clears off). An unsupported BE is treated as word.

Test Plan:
- Reset release: REQ_READY=0 during reset and 1 one cycle after; RSP_VALID=0; D_MEM_DOUT=0.
- Store word 0xDEADBEEF @0x010 then load word @0x010, LATENCY=2 -> RSP_VALID 2 cycles after each accept; load D_MEM_DOUT=0xDEADBEEF.
- Store byte 0x80 @0x013, then load byte @0x013 with is_sign=1 -> 0xFFFFFF80; with is_sign=0 -> 0x00000080; load word @0x010 -> 0x80ADBEEF.
- Store half 0x8001 @0x022, then load half signed @0x022 -> 0xFFFF8001; load half @0x020 -> prior contents unchanged.
- Hold RSP_READY=0 for 5 cycles in RESP -> RSP_VALID stays 1, data stable, REQ_READY=0, and a new REQ_VALID is ignored; release -> IDLE next cycle.
- With DMEM_ERR_RESP_EN: store word @0x031 -> MISALIGN=1, D_MEM_DOUT=0, memory unchanged. Also assert RSTn=0 during WAIT of a store @0x040 -> no response, and a subsequent load @0x040 returns the old value.
